// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO push-port arbiter.
//   DATA_WIDTH  : default FIFO data width
//   ADDR_WIDTH  : FIFO address width used by the surrounding FIFO
//   arb_state_e : arbiter FSM state encoding
package fifo_arb_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin requester search: first set bit of req at or after rr_ptr,
// wrapping modulo NUM_REQ.
//   req    in  : per-producer request bits
//   rr_ptr in  : search start index (< NUM_REQ)
//   found  out : any request bit set
//   idx    out : selected requester index (0 when !found)
module fifo_arb_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Walk offsets 0..NUM_REQ-1 from rr_ptr; first hit wins.
  always_comb begin
    int unsigned cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO push port between NUM_REQ producers.
// A producer holds the port for a tenure of up to MAX_BURST beats, ending
// early on req_last or when it drops req.
//   clk, rst_n        : clock, async active-low reset
//   req/req_data/req_last : per-producer beat valid, data, end-of-packet
//   gnt               : one-hot beat accept (same-cycle, combinational)
//   push, data_in     : FIFO write strobe and data (data_in holds when idle)
//   full              : FIFO full, stalls the current beat
//   push_err_on_full  : FIFO overflow flag, counted into err_cnt
//   owner, busy       : current grant holder and tenure-active flag
//   err_cnt           : saturating overflow-cycle count
module fifo_push_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          push,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          push_err_on_full,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [7:0]                    err_cnt
);

  import fifo_arb_pkg::*;

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [7:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    gnt_c;
  logic                  push_c;
  logic [DATA_WIDTH-1:0] owner_data;
  logic [IDX_W-1:0]      owner_nxt;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Owner's beat data and the round-robin successor of the owner.
  assign owner_data = req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
  assign owner_nxt  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Next-state and same-cycle beat acceptance.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    data_d  = data_q;
    gnt_c   = '0;
    push_c  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!req[owner_q]) begin
          // Owner withdrew: end the tenure without a push.
          state_d = ARB_IDLE;
          rr_d    = owner_nxt;
        end else if (!full) begin
          gnt_c[owner_q] = 1'b1;
          push_c         = 1'b1;
          data_d         = owner_data;
          if (req_last[owner_q] || (beat_q == BEAT_W'(MAX_BURST - 1))) begin
            state_d = ARB_IDLE;
            rr_d    = owner_nxt;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Saturating overflow counter.
  always_comb begin
    err_d = err_q;
    if (push_err_on_full && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  assign gnt     = gnt_c;
  assign push    = push_c;
  assign data_in = push_c ? owner_data : data_q;
  assign busy    = (state_q == ARB_GRANT);
  assign owner   = owner_q;
  assign err_cnt = err_q;

endmodule
